// File: rtl/src_addr_seq.sv
// src_addr_seq: memory address source mux with an exception-vector fetch sequencer
module src_addr_seq #(
  parameter int WIDTH         = 32,
  parameter int VEC_BASE      = 253,
  parameter int HANDLER_BYTES = 1,
  parameter int MEM_LAT       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] iord_addr,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  input  logic             exc_req,
  input  logic [1:0]       exc_code,
  input  logic [7:0]       mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic             exc_busy,
  output logic             exc_done,
  output logic             exc_err,
  output logic [WIDTH-1:0] handler_addr
);
  localparam int BW = $clog2(HANDLER_BYTES + 1);
  localparam int LW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] norm, mem_nx, hnd_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic [LW-1:0] lcnt, lcnt_nx;
  logic [1:0] code, code_nx;
  logic err_nx;
  // Byte address of vector entry k, byte i; wraps at WIDTH bits
  function automatic logic [WIDTH-1:0] vec(input logic [1:0] k, input logic [BW-1:0] i);
    return WIDTH'(VEC_BASE) + WIDTH'(k) * WIDTH'(HANDLER_BYTES) + WIDTH'(i);
  endfunction
  // Normal-mode source selection; sel 1..3 map to byte 0 of codes 0..2
  always_comb
    norm = (sel == 3'd0) ? iord_addr :
           (sel == 3'd4) ? a_val :
           (sel == 3'd5) ? b_val :
           (sel[2:1] == 2'b11) ? '0 : vec(sel[1:0] - 2'd1, '0);
  // Next-state and datapath update; the last byte gets one settling cycle before DONE
  always_comb begin
    state_nx = state;
    mem_nx   = norm;
    hnd_nx   = handler_addr;
    bcnt_nx  = bcnt;
    lcnt_nx  = lcnt;
    code_nx  = code;
    err_nx   = 1'b0;
    case (state)
      IDLE:
        if (exc_req && exc_code != 2'd3) begin
          state_nx = FETCH;
          code_nx  = exc_code;
          hnd_nx   = '0;
          mem_nx   = vec(exc_code, '0);
          lcnt_nx  = LW'(MEM_LAT);
          bcnt_nx  = '0;
        end else if (exc_req) begin
          err_nx = 1'b1;
        end
      FETCH: begin
        mem_nx = mem_addr;
        if (lcnt == '0) begin
          state_nx = DONE;
        end else begin
          lcnt_nx = lcnt - 1'b1;
          if (lcnt == LW'(1)) begin
            hnd_nx[{bcnt, 3'b000} +: 8] = mem_rdata;
            if (bcnt != BW'(HANDLER_BYTES - 1)) begin
              bcnt_nx = bcnt + 1'b1;
              mem_nx  = vec(code, bcnt + 1'b1);
              lcnt_nx = LW'(MEM_LAT);
            end
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      mem_addr     <= '0;
      handler_addr <= '0;
      bcnt         <= '0;
      lcnt         <= '0;
      code         <= '0;
      exc_err      <= 1'b0;
    end else begin
      state        <= state_nx;
      mem_addr     <= mem_nx;
      handler_addr <= hnd_nx;
      bcnt         <= bcnt_nx;
      lcnt         <= lcnt_nx;
      code         <= code_nx;
      exc_err      <= err_nx;
    end
  assign exc_busy = (state == FETCH);
  assign exc_done = (state == DONE);
endmodule

// File: tb/tb_src_addr_seq.sv
// tb_src_addr_seq: directed self-checking bench for src_addr_seq (default and 4-byte/2-cycle builds)
module tb_src_addr_seq;
  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] sel;
  logic [31:0] iord_addr, a_val, b_val;
  logic req0, req1;
  logic [1:0] code0, code1;
  logic [7:0] rd0, rd1;
  logic [31:0] addr0, addr1, hnd0, hnd1;
  logic busy0, busy1, done0, done1, err0, err1;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [31:0] a);
    case (a)
      32'd253: return 8'hA1;
      32'd254: return 8'h8C;
      32'd255: return 8'h5E;
      32'd256: return 8'h77;
      32'd261: return 8'h11;
      32'd262: return 8'h22;
      32'd263: return 8'h33;
      32'd264: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction
  assign rd0 = mem(addr0);
  assign rd1 = mem(addr1);

  src_addr_seq u0 (
    .clk(clk), .reset_n(reset_n), .sel(sel), .iord_addr(iord_addr), .a_val(a_val), .b_val(b_val),
    .exc_req(req0), .exc_code(code0), .mem_rdata(rd0), .mem_addr(addr0), .exc_busy(busy0),
    .exc_done(done0), .exc_err(err0), .handler_addr(hnd0)
  );
  src_addr_seq #(.HANDLER_BYTES(4), .MEM_LAT(2)) u1 (
    .clk(clk), .reset_n(reset_n), .sel(sel), .iord_addr(iord_addr), .a_val(a_val), .b_val(b_val),
    .exc_req(req1), .exc_code(code1), .mem_rdata(rd1), .mem_addr(addr1), .exc_busy(busy1),
    .exc_done(done1), .exc_err(err1), .handler_addr(hnd1)
  );

  task automatic test_reset;
    reset_n = 1'b0; sel = 3'd0; iord_addr = 32'h40; a_val = 32'h1000; b_val = 32'h2000;
    req0 = 1'b0; req1 = 1'b0; code0 = 2'd0; code1 = 2'd0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({addr0, hnd0, busy0, done0, err0} !== 67'd0) begin
      n_fail++; $display("FAIL reset_u0 got addr=%h hnd=%h b/d/e=%b%b%b want all 0", addr0, hnd0, busy0, done0, err0);
    end
    n_chk++;
    if ({addr1, hnd1, busy1, done1, err1} !== 67'd0) begin
      n_fail++; $display("FAIL reset_u1 got addr=%h hnd=%h b/d/e=%b%b%b want all 0", addr1, hnd1, busy1, done1, err1);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_normal;
    logic [31:0] e0 [8] = '{32'h40, 32'd253, 32'd254, 32'd255, 32'h1000, 32'h2000, 32'd0, 32'd0};
    logic [31:0] e1 [8] = '{32'h40, 32'd253, 32'd257, 32'd261, 32'h1000, 32'h2000, 32'd0, 32'd0};
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      @(negedge clk);
      n_chk++;
      if (addr0 !== e0[s]) begin
        n_fail++; $display("FAIL normal_u0 sel=%0d got %h want %h", s, addr0, e0[s]);
      end
      n_chk++;
      if (addr1 !== e1[s]) begin
        n_fail++; $display("FAIL normal_u1 sel=%0d got %h want %h", s, addr1, e1[s]);
      end
    end
  endtask

  task automatic test_fetch_default;
    sel = 3'd0; code0 = 2'd1; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    n_chk++;
    if (addr0 !== 32'd254 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      n_fail++; $display("FAIL fetch1_accept got addr=%0d busy=%b done=%b want 254 1 0", addr0, busy0, done0);
    end
    @(negedge clk);
    n_chk++;
    if (addr0 !== 32'd254 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      n_fail++; $display("FAIL fetch1_wait got addr=%0d busy=%b done=%b want 254 1 0", addr0, busy0, done0);
    end
    @(negedge clk);
    n_chk++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || hnd0 !== 32'h8C) begin
      n_fail++; $display("FAIL fetch1_done got done=%b busy=%b hnd=%h want 1 0 0000008c", done0, busy0, hnd0);
    end
    @(negedge clk);
    n_chk++;
    if (done0 !== 1'b0 || addr0 !== 32'h40 || hnd0 !== 32'h8C) begin
      n_fail++; $display("FAIL fetch1_after got done=%b addr=%h hnd=%h want 0 40 8c", done0, addr0, hnd0);
    end
  endtask

  task automatic test_fetch_wide;
    sel = 3'd6; code1 = 2'd2; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    n_chk++;
    if (addr1 !== 32'd261 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL fetch4_accept got addr=%0d busy=%b want 261 1", addr1, busy1);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_chk++;
      if (done1 !== (k == 9) || busy1 !== (k < 9)) begin
        n_fail++; $display("FAIL fetch4_flags k=%0d got done=%b busy=%b want %b %b", k, done1, busy1, k == 9, k < 9);
      end
      if (k < 9) begin
        n_chk++;
        if (addr1 !== 32'd261 + 32'((k / 2 > 3) ? 3 : k / 2)) begin
          n_fail++; $display("FAIL fetch4_addr k=%0d got %0d want %0d", k, addr1, 261 + ((k / 2 > 3) ? 3 : k / 2));
        end
      end
    end
    n_chk++;
    if (hnd1 !== 32'h44332211) begin
      n_fail++; $display("FAIL fetch4_handler got %h want 44332211", hnd1);
    end
  endtask

  task automatic test_reserved;
    sel = 3'd4; code0 = 2'd3; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    n_chk++;
    if (err0 !== 1'b1 || busy0 !== 1'b0 || addr0 !== 32'h1000 || hnd0 !== 32'h8C) begin
      n_fail++; $display("FAIL reserved got err=%b busy=%b addr=%h hnd=%h want 1 0 1000 8c", err0, busy0, addr0, hnd0);
    end
    @(negedge clk);
    n_chk++;
    if (err0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_fail++; $display("FAIL reserved_pulse got err=%b busy=%b done=%b want 0 0 0", err0, busy0, done0);
    end
  endtask

  task automatic test_ignore_req;
    int dones = 0;
    code0 = 2'd0; req0 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 4) req0 = 1'b0;
      dones += int'(done0);
    end
    n_chk++;
    if (dones != 1 || busy0 !== 1'b0 || hnd0 !== 32'hA1) begin
      n_fail++; $display("FAIL ignore_req got dones=%0d busy=%b hnd=%h want 1 0 a1", dones, busy0, hnd0);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int seen = 0;
    sel = 3'd7; code1 = 2'd2; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      dones += int'(done1);
    end
    n_chk++;
    if (busy1 !== 1'b1 || hnd1 !== 32'h2211) begin
      n_fail++; $display("FAIL midreset_pre got busy=%b hnd=%h want 1 00002211", busy1, hnd1);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({addr1, hnd1, busy1, done1, err1} !== 67'd0) begin
      n_fail++; $display("FAIL midreset_async got addr=%h hnd=%h b/d/e=%b%b%b want all 0", addr1, hnd1, busy1, done1, err1);
    end
    @(negedge clk);
    dones += int'(done1);
    reset_n = 1'b1;
    @(negedge clk);
    dones += int'(done1);
    n_chk++;
    if (dones != 0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL midreset_nodone got dones=%0d busy=%b want 0 0", dones, busy1);
    end
    code1 = 2'd0; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done1 && seen == 0) seen = k;
      dones += int'(done1);
    end
    n_chk++;
    if (seen != 9 || dones != 1) begin
      n_fail++; $display("FAIL refetch_timing got done_at=%0d count=%0d want 9 1", seen, dones);
    end
    n_chk++;
    if (hnd1 !== 32'h775E8CA1) begin
      n_fail++; $display("FAIL refetch_handler got %h want 775e8ca1", hnd1);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_fetch_default;
    test_fetch_wide;
    test_reserved;
    test_ignore_req;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
